// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display constants: digit count and active-low segment
// patterns ordered g..a as seg[6:0].
package stopwatch_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decode; non-BCD codes
// (10..15) render as a dash.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: prescaled digit scan over a
// frame snapshot of the BCD inputs, with optional leading-zero blanking.
module seg7_scan_driver
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DP_POS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] s3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0]            presc_p0;
  logic [1:0]               idx_p0;
  logic [DIGITS-1:0][3:0]   shadow_p0;
  logic                     vld_p1;
  logic                     tick;
  logic [6:0]               seg_dec;

  // A digit is suppressed when it and every more-significant digit are zero,
  // but never at or right of the decimal point, and never digit 0.
  function automatic logic lz_blank(input logic [1:0] k,
                                    input logic [DIGITS-1:0][3:0] frame);
    logic [15:0] upper;
    upper = 16'(frame) >> (4 * int'(k));
    return (BLANK_LZ != 0) && (k != 2'd0) && (int'(k) > DP_POS) && (upper == 16'd0);
  endfunction

  assign tick = (presc_p0 == PMAX);

  bcd_to_seg u_dec (
    .bcd (shadow_p0[idx_p0]),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_p0  <= '0;
      idx_p0    <= 2'd3;
      shadow_p0 <= '0;
      vld_p1    <= 1'b0;
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      // stage 0: prescaler, scan index and frame snapshot
      presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
      vld_p1   <= tick;
      if (tick) begin
        idx_p0 <= idx_p0 + 2'd1;
        if (idx_p0 == 2'd3)
          shadow_p0 <= {s3, s2, s1, s0};
      end
      // stage 1: drive the pins from the freshly advanced index
      if (vld_p1) begin
        an  <= ~(4'b0001 << idx_p0);
        seg <= lz_blank(idx_p0, shadow_p0) ? SEG_BLANK : seg_dec;
        dp  <= (int'(idx_p0) != DP_POS);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three parameterisations driven from shared
// inputs, checked against a frame/slot arithmetic model.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s0, s1, s2, s3;
  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  logic [15:0] hist [4096];

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(4), .DP_POS(4), .BLANK_LZ(0)) dut_a (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .an(an_a), .seg(seg_a), .dp(dp_a));
  seg7_scan_driver #(.SCAN_DIV(4), .DP_POS(2), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .an(an_b), .seg(seg_b), .dp(dp_b));
  seg7_scan_driver #(.SCAN_DIV(1), .DP_POS(4), .BLANK_LZ(0)) dut_c (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .an(an_c), .seg(seg_c), .dp(dp_c));

  // Input history per released clock edge; ncyc = edges since reset release.
  always @(posedge clk) begin
    if (!reset) ncyc <= 0;
    else begin
      hist[ncyc % 4096] <= {s3, s2, s1, s0};
      ncyc <= ncyc + 1;
    end
  end

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an, seg, dp} after n released edges. Tick t falls on edge
  // t*d+d-1, the display shows digit t%4 from edge t*d+d, and the frame
  // snapshot is the input seen at the tick that started that frame.
  function automatic logic [11:0] model(input int d, input int dpp, input int blz, input int n);
    int t, k, e, v, upper;
    logic [15:0] snap;
    logic [6:0]  sg;
    logic [3:0]  a;
    if (n < d + 1) return 12'hFFF;
    t = (n - 1 - d) / d;
    k = t % 4;
    e = (t - k) * d + d - 1;
    snap  = hist[e % 4096];
    upper = int'(snap) >> (4 * k);
    v     = upper & 15;
    sg    = pat(v);
    if (blz != 0 && k > 0 && k > dpp && upper == 0) sg = 7'b1111111;
    a = 4'hF;
    a[k] = 1'b0;
    return {a, sg, (k == dpp) ? 1'b0 : 1'b1};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_s(input logic [15:0] v);
    {s3, s2, s1, s0} = v;
  endtask

  task automatic test_reset();
    set_s(16'h1234);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({an_a, seg_a, dp_a} !== 12'hFFF) begin
        bad++; $display("FAIL reset_a got %h want fff", {an_a, seg_a, dp_a});
      end
      total++;
      if ({an_b, seg_b, dp_b} !== 12'hFFF) begin
        bad++; $display("FAIL reset_b got %h want fff", {an_b, seg_b, dp_b});
      end
      total++;
      if ({an_c, seg_c, dp_c} !== 12'hFFF) begin
        bad++; $display("FAIL reset_c got %h want fff", {an_c, seg_c, dp_c});
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [11:0] exp;
    set_s(16'h4321);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp = model(4, 4, 0, ncyc);
      total++;
      if ({an_a, seg_a, dp_a} !== exp) begin
        bad++; $display("FAIL basic n=%0d got %h want %h", ncyc, {an_a, seg_a, dp_a}, exp);
      end
      if (ncyc == 4) begin
        total++;
        if (an_a !== 4'b1111) begin
          bad++; $display("FAIL basic_early an got %b want 1111", an_a);
        end
      end
      if (ncyc == 5) begin
        total++;
        if ({an_a, seg_a, dp_a} !== {4'b1110, 7'b1111001, 1'b1}) begin
          bad++; $display("FAIL basic_first got %b want 1110_1111001_1", {an_a, seg_a, dp_a});
        end
      end
      if (ncyc == 17) begin
        total++;
        if ({an_a, seg_a} !== {4'b0111, 7'b0011001}) begin
          bad++; $display("FAIL basic_d3 got %b want 0111_0011001", {an_a, seg_a});
        end
      end
    end
  endtask

  task automatic test_blank();
    logic [11:0] exp;
    set_s(16'h0000);
    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp = model(4, 2, 1, ncyc);
      total++;
      if ({an_b, seg_b, dp_b} !== exp) begin
        bad++; $display("FAIL blank n=%0d got %h want %h", ncyc, {an_b, seg_b, dp_b}, exp);
      end
      if (ncyc == 14) begin
        total++;
        if ({an_b, seg_b, dp_b} !== {4'b1011, 7'b1000000, 1'b0}) begin
          bad++; $display("FAIL blank_d2 got %b want 1011_1000000_0", {an_b, seg_b, dp_b});
        end
      end
      if (ncyc == 18) begin
        total++;
        if ({an_b, seg_b, dp_b} !== {4'b0111, 7'b1111111, 1'b1}) begin
          bad++; $display("FAIL blank_d3 got %b want 0111_1111111_1", {an_b, seg_b, dp_b});
        end
      end
      if (ncyc == 10) begin
        total++;
        if ({an_b, seg_b, dp_b} !== {4'b1101, 7'b1000000, 1'b1}) begin
          bad++; $display("FAIL blank_d1 got %b want 1101_1000000_1", {an_b, seg_b, dp_b});
        end
      end
    end
  endtask

  task automatic test_no_tear();
    logic [11:0] exp;
    set_s(16'h0001);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp = model(4, 4, 0, ncyc);
      total++;
      if ({an_a, seg_a, dp_a} !== exp) begin
        bad++; $display("FAIL tear n=%0d got %h want %h", ncyc, {an_a, seg_a, dp_a}, exp);
      end
      if (ncyc == 22) begin
        total++;
        if ({an_a, seg_a} !== {4'b1110, 7'b0100100}) begin
          bad++; $display("FAIL tear_next_frame got %b want 1110_0100100", {an_a, seg_a});
        end
      end
      if (ncyc == 10) s0 = 4'd2;
    end
  endtask

  task automatic test_dash_nines();
    logic [11:0] exp;
    set_s(16'h00B0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ncyc == 10) begin
        total++;
        if ({an_a, seg_a} !== {4'b1101, 7'b0111111}) begin
          bad++; $display("FAIL dash got %b want 1101_0111111", {an_a, seg_a});
        end
      end
    end
    set_s(16'h9999);
    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp = model(4, 4, 0, ncyc);
      total++;
      if ({an_a, seg_a, dp_a} !== exp) begin
        bad++; $display("FAIL nines n=%0d got %h want %h", ncyc, {an_a, seg_a, dp_a}, exp);
      end
      if (ncyc >= 5 && ncyc <= 20) begin
        total++;
        if (seg_a !== 7'b0010000) begin
          bad++; $display("FAIL nines_seg n=%0d got %b want 0010000", ncyc, seg_a);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    set_s(16'h5678);
    do_reset();
    while (ncyc != 14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({an_a, seg_a, dp_a} !== 12'hFFF) begin
      bad++; $display("FAIL reset_mid got %h want fff", {an_a, seg_a, dp_a});
    end
    total++;
    if ({an_b, seg_b, dp_b} !== 12'hFFF) begin
      bad++; $display("FAIL reset_mid_b got %h want fff", {an_b, seg_b, dp_b});
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp = model(4, 4, 0, ncyc);
      total++;
      if ({an_a, seg_a, dp_a} !== exp) begin
        bad++; $display("FAIL reset_mid_run n=%0d got %h want %h", ncyc, {an_a, seg_a, dp_a}, exp);
      end
      if (ncyc == 5) begin
        total++;
        if ({an_a, seg_a} !== {4'b1110, 7'b0000000}) begin
          bad++; $display("FAIL reset_mid_restart got %b want 1110_0000000", {an_a, seg_a});
        end
      end
    end
  endtask

  task automatic test_fast_scan();
    logic [11:0] exp;
    logic [3:0]  want_an;
    set_s(16'(($urandom & 32'hFFFF)));
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = model(1, 4, 0, ncyc);
      total++;
      if ({an_c, seg_c, dp_c} !== exp) begin
        bad++; $display("FAIL fast n=%0d got %h want %h", ncyc, {an_c, seg_c, dp_c}, exp);
      end
      if (ncyc >= 2) begin
        want_an = 4'hF;
        want_an[(ncyc - 2) % 4] = 1'b0;
        total++;
        if (an_c !== want_an) begin
          bad++; $display("FAIL fast_rotate n=%0d got %b want %b", ncyc, an_c, want_an);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] ea, eb, ec;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ea = model(4, 4, 0, ncyc);
      eb = model(4, 2, 1, ncyc);
      ec = model(1, 4, 0, ncyc);
      total++;
      if ({an_a, seg_a, dp_a} !== ea) begin
        bad++; $display("FAIL rand_a n=%0d got %h want %h", ncyc, {an_a, seg_a, dp_a}, ea);
      end
      total++;
      if ({an_b, seg_b, dp_b} !== eb) begin
        bad++; $display("FAIL rand_b n=%0d got %h want %h", ncyc, {an_b, seg_b, dp_b}, eb);
      end
      total++;
      if ({an_c, seg_c, dp_c} !== ec) begin
        bad++; $display("FAIL rand_c n=%0d got %h want %h", ncyc, {an_c, seg_c, dp_c}, ec);
      end
      if ($urandom_range(0, 7) == 0) begin
        // Bias toward zeros so leading-zero blanking is exercised.
        s0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        s1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        s2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        s3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    set_s(16'h0000);
    @(negedge clk);
    test_reset();
    test_basic();
    test_blank();
    test_no_tear();
    test_dash_nines();
    test_reset_mid();
    test_fast_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SCAN_DIV, 100000, clocks per digit slot; legal range is 1 or more.
- DP_POS, 2, digit index whose decimal point is lit; 4 means no decimal point.
- BLANK_LZ, 1, 1 enables leading-zero blanking.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock.
- reset, input, 1, synchronous active-low reset.
- s0, input, 4, BCD digit 0 (least significant).
- s1, input, 4, BCD digit 1.
- s2, input, 4, BCD digit 2.
- s3, input, 4, BCD digit 3 (most significant).
- an, output, 4, digit enables, active-low; an[k] selects digit k.
- seg, output, 7, segments g..a as seg[6:0], active-low.
- dp, output, 1, decimal point, active-low.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL be true when the prescaler equals SCAN_DIV-1; with SCAN_DIV=1, tick SHALL be true every cycle.

REQ-005 The 2-bit scan index SHALL advance by 1 on each tick clock edge and wrap from 3 to 0.

REQ-006 On a tick edge where the index wraps 3->0, s0..s3 SHALL be captured into shadow registers; the display SHALL use only shadow values, so a frame never tears.

REQ-007 On the clock edge after a tick, an, seg and dp SHALL update from the new index and the shadow registers (1-cycle latency), then hold until the next update.

REQ-008 an SHALL be one-hot active-low, with an[idx]=0.

REQ-009 seg decode SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Values 10..15 SHALL show a dash, 0111111.

REQ-010 With BLANK_LZ=1, digit k (k=3..1) SHALL be blanked when shadow digits k..3 are all 0 and k>DP_POS.
- A blanked digit SHALL show seg=1111111 with an still asserted.
- Digit 0 SHALL never be blanked.
- With BLANK_LZ=0, no digit SHALL be blanked.

REQ-011 dp SHALL be 0 only while idx==DP_POS, and SHALL be 1 always when DP_POS=4.

REQ-012 Input changes between snapshots SHALL have no effect on outputs.

Reset
REQ-013 While reset=0 at a clock edge, the block SHALL set:
- prescaler=0
- idx=3
- shadows=0
- an=1111
- seg=1111111
- dp=1

REQ-014 Reset asserted mid-scan SHALL take effect at that edge, overriding any tick.

REQ-015 After release, the first tick SHALL wrap idx to 0 and snapshot; digit 0 SHALL appear one cycle later.

Structure
REQ-016 Segment patterns (digits 0..9, SEG_DASH, SEG_BLANK) and the digit count of 4 SHALL live in the shared stopwatch_pkg package.

REQ-017 BCD-to-segment decode SHALL be a combinational sub-module bcd_to_seg (4-bit in, 7-bit out), instantiated once on the shadow digit selected by the next idx.

REQ-018 The block SHALL connect directly to the stopwatch BCD counter outputs s0..s3.

Verification (SCAN_DIV=4 unless stated)
REQ-019 Hold reset=0 for 2 cycles, then release with s3..s0=4,3,2,1, DP_POS=4, BLANK_LZ=0.
- an SHALL sequence 1110, 1101, 1011, 0111, each held 4 cycles.
- The first update SHALL occur at cycle 5 after release.
- seg SHALL read 1111001, 0100100, 0110000, 0011001; dp SHALL stay 1.

REQ-020 Apply s3..s0=0,0,0,0 with DP_POS=2 and BLANK_LZ=1.
- Digit 3 SHALL show 1111111.
- Digit 2 SHALL show 1000000 with dp=0.
- Digits 1 and 0 SHALL show 1000000 with dp=1.

REQ-021 Change s0 from 1 to 2 while idx=1.
- Digit 0 SHALL remain 1111001 for the rest of the frame.
- Digit 0 SHALL show 0100100 only after the next 3->0 wrap.

REQ-022 Apply s1=4'hB → digit 1 SHALL show 0111111; with s3..s0=9,9,9,9, all digits SHALL show 0010000.

REQ-023 Assert reset at idx=2 mid-slot → at the next edge an=1111, seg=1111111, dp=1, prescaler=0; the scan SHALL restart per REQ-015.

REQ-024 Run SCAN_DIV=1 with BLANK_LZ=0 → an SHALL rotate every cycle with no skipped digit over 8 cycles.
